control_unit_mc: RTL and testbench
==================================

Name: control_unit_mc

Overview:
- Multicycle control FSM that drives the instruction fetch/decode datapath: WE_mem, WE_reg, OP_MEM_I, ADD_SUB, PC_load and select_flags.
- Sits directly upstream of that datapath. It consumes the instruction word the datapath's instruction ROM outputs and sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Counts retired instructions and halts on an unsupported opcode.

Parameters:
- COUNT_W, 16, width of the retired-instruction counter.
- HALT_ON_ILLEGAL, 1: 1 = an illegal opcode enters HALT; 0 = the illegal instruction is retired as a NOP.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- run  input  1  start/continue execution; sampled at instruction boundaries only.
- instruction  input  32  instruction word from the instruction ROM at the current PC.
- WE_mem  output  1  data memory write strobe.
- WE_reg  output  1  register bank write strobe.
- OP_MEM_I  output  2  bit0 = ALU B operand is the immediate; bit1 = writeback source is memory data.
- ADD_SUB  output  1  0 = add, 1 = subtract.
- PC_load  output  1  single-cycle PC update strobe.
- select_flags  output  3  3'd0..3'd5 = flags[0..5] select the branch condition; 3'd6 = forced PC+1; 3'd7 = forced taken.
- state  output  3  current FSM state (debug).
- instr_count  output  COUNT_W  retired-instruction counter.
- halted  output  1  FSM is in HALT.

Behaviour:
- Reset (reset=0, asynchronous):
  - state = IDLE; IR = 0; instr_count = 0.
  - All strobes = 0; OP_MEM_I = 0; select_flags = 3'd6; halted = 0.
  - Takes effect immediately, mid-instruction included; no partial writes complete.
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=7.
- Outputs are Moore functions of state and the latched IR only. There is no combinational path from instruction to any output.
- IDLE: if run=1, go to FETCH; otherwise stay.
- FETCH: latch instruction into IR; go to DECODE.
- DECODE: classify IR[6:0].
  - R = 0110011, I-ALU = 0010011, LOAD = 0000011, STORE = 0100011, BRANCH = 1100011.
  - Any other opcode: go to HALT if HALT_ON_ILLEGAL=1. If HALT_ON_ILLEGAL=0, assert PC_load with select_flags = 6, count the instruction as retired, and go to the boundary.
  - Legal opcode: go to EXEC.
- EXEC:
  - ADD_SUB = 1 for R-type with funct3 = 000 and IR[30] = 1, and for every BRANCH. Otherwise ADD_SUB = 0.
  - OP_MEM_I[0] = 1 for I-ALU, LOAD and STORE.
  - BRANCH finishes here with PC_load = 1. select_flags is taken from funct3:
    - 000 -> 0, 001 -> 1, 100 -> 2, 101 -> 3, 110 -> 4, 111 -> 5.
    - 010 and 011 -> 6 (not taken, falls through to PC+1).
  - Next state: LOAD and STORE go to MEM; R and I-ALU go to WB.
- MEM:
  - STORE: WE_mem = 1 and PC_load = 1 (select_flags = 6); instruction completes.
  - LOAD: go to WB.
- WB:
  - WE_reg = 1 and PC_load = 1 (select_flags = 6).
  - OP_MEM_I[1] = 1 for LOAD.
  - ADD_SUB and OP_MEM_I[0] are held at their EXEC values for every opcode that reaches WB.
- ADD_SUB and OP_MEM_I hold their EXEC values through MEM as well.
- Latency: R/I-ALU 4 cycles, LOAD 5, STORE 4, BRANCH 3.
- Boundary rule (completion cycle):
  - Each strobe asserts for exactly one cycle per instruction.
  - instr_count increments on the completion cycle and wraps at 2^COUNT_W - 1 -> 0.
  - Next state is FETCH if run=1, otherwise IDLE.
  - Deasserting run mid-instruction never aborts the instruction; it finishes first.
- HALT: halted = 1, all strobes = 0, no PC_load. HALT is left only via reset; run is ignored.
- Rd = x0 is not special-cased here; the datapath handles it.

Test Plan:
- Reset then run=1 with R-type sub (funct7 = 0100000, funct3 = 000, opcode 0110011):
  - state sequence 1, 2, 3, 5.
  - ADD_SUB = 1 in EXEC and WB; WE_reg = 1 and PC_load = 1 only in WB; instr_count = 1.
- LOAD (opcode 0000011) followed by STORE (opcode 0100011):
  - LOAD takes 5 cycles with OP_MEM_I = 2'b11 in WB; STORE takes 4 cycles with WE_mem = 1 in MEM.
  - WE_reg is never high during the STORE; instr_count = 2.
- BRANCH with funct3 = 101, then funct3 = 011:
  - PC_load in EXEC with select_flags = 3; then select_flags = 6.
  - Each instruction takes 3 cycles; WE_reg = WE_mem = 0 throughout.
- Illegal opcode 1101111:
  - HALT_ON_ILLEGAL=1: halted = 1 after DECODE, no further strobes for 20 cycles with run=1, instr_count unchanged.
  - HALT_ON_ILLEGAL=0: NOP retired, PC_load in DECODE.
- reset=0 pulsed in MEM of a STORE:
  - WE_mem drops in the same cycle and state = 0; instr_count = 0.
  - run deasserted during EXEC of an R-type: instruction completes in WB, then FSM returns to IDLE.
- COUNT_W = 4, 16 back-to-back I-ALU instructions: instr_count wraps 15 -> 0.

Source files
------------

// File: rtl/control_unit_mc.sv
// -----------------------------------------------------------------------------
// control_unit_mc
//
// Multicycle control FSM for the instruction fetch/decode datapath. Each
// instruction is sequenced through FETCH / DECODE / EXEC / (MEM) / (WB). The
// unit also counts retired instructions and stops in HALT on an unsupported
// opcode, or retires it as a NOP, depending on HALT_ON_ILLEGAL.
//
// Parameters
//   COUNT_W          width of the retired-instruction counter
//   HALT_ON_ILLEGAL  1: an illegal opcode enters HALT; 0: it retires as a NOP
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   asynchronous active-low reset
//   run           in   start/continue; sampled only at instruction boundaries
//   instruction   in   [31:0] instruction word from the ROM at the current PC
//   WE_mem        out  data memory write strobe
//   WE_reg        out  register bank write strobe
//   OP_MEM_I      out  [1:0] bit0 = ALU B is immediate, bit1 = WB from memory
//   ADD_SUB       out  0 = add, 1 = subtract
//   PC_load       out  single-cycle PC update strobe
//   select_flags  out  [2:0] 0..5 = flag select, 6 = PC+1, 7 = forced taken
//   state         out  [2:0] current FSM state (debug)
//   instr_count   out  [COUNT_W-1:0] retired-instruction counter
//   halted        out  FSM is in HALT
//
// There is no handshake on this block: run is a level that is only looked at
// on the completion cycle of an instruction (or in IDLE), so dropping it never
// aborts an instruction in flight.
//
// All outputs are registered. Their next values are decoded from the next
// state and the next IR, so each output is a Moore function of the state and
// the latched IR as seen in the same cycle, with no path from the instruction
// input to any output.
// -----------------------------------------------------------------------------
module control_unit_mc #(
    parameter int COUNT_W         = 16,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic [31:0]        instruction,
    output logic               WE_mem,
    output logic               WE_reg,
    output logic [1:0]         OP_MEM_I,
    output logic               ADD_SUB,
    output logic               PC_load,
    output logic [2:0]         select_flags,
    output logic [2:0]         state,
    output logic [COUNT_W-1:0] instr_count,
    output logic               halted
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd7
    } state_e;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // select_flags value meaning "no branch, PC <= PC + 1"
    localparam logic [2:0] SEL_PC_INC = 3'd6;

    // ------------------------------------------------------------------
    // State and datapath-facing registers
    // ------------------------------------------------------------------
    state_e               state_q, state_d;
    logic [31:0]          ir_q, ir_d;
    logic [COUNT_W-1:0]   cnt_q, cnt_d;

    logic                 we_mem_q, we_mem_d;
    logic                 we_reg_q, we_reg_d;
    logic [1:0]           op_mem_i_q, op_mem_i_d;
    logic                 add_sub_q, add_sub_d;
    logic                 pc_load_q, pc_load_d;
    logic [2:0]           sel_q, sel_d;
    logic                 halted_q, halted_d;

    logic                 retire;

    // ------------------------------------------------------------------
    // IR capture and decode. The IR only changes in FETCH, so decoding the
    // next IR gives the class of the instruction that the next state acts on.
    // ------------------------------------------------------------------
    assign ir_d = (state_q == S_FETCH) ? instruction : ir_q;

    logic [6:0] opc;
    logic [2:0] funct3;
    logic       is_r, is_i, is_load, is_store, is_branch, is_legal;
    logic       alu_sub, alu_imm;
    logic [2:0] branch_sel;
    logic       unused_ir_bits;

    assign opc       = ir_d[6:0];
    assign funct3    = ir_d[14:12];
    assign is_r      = (opc == OPC_R);
    assign is_i      = (opc == OPC_I);
    assign is_load   = (opc == OPC_LOAD);
    assign is_store  = (opc == OPC_STORE);
    assign is_branch = (opc == OPC_BRANCH);
    assign is_legal  = is_r | is_i | is_load | is_store | is_branch;

    // Branches compare by subtracting; R-type SUB is funct3=000 with bit 30.
    assign alu_sub = (is_r && (funct3 == 3'b000) && ir_d[30]) || is_branch;
    assign alu_imm = is_i | is_load | is_store;

    // Register fields are consumed by the datapath, not here.
    assign unused_ir_bits = ^{ir_d[31], ir_d[29:15], ir_d[11:7]};

    // funct3 -> flag index; the two reserved encodings fall through to PC+1.
    always_comb begin
        branch_sel = SEL_PC_INC;
        case (funct3)
            3'b000:  branch_sel = 3'd0;
            3'b001:  branch_sel = 3'd1;
            3'b100:  branch_sel = 3'd2;
            3'b101:  branch_sel = 3'd3;
            3'b110:  branch_sel = 3'd4;
            3'b111:  branch_sel = 3'd5;
            default: branch_sel = SEL_PC_INC;
        endcase
    end

    // ------------------------------------------------------------------
    // Next state, counter and next output values
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retire  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_legal) begin
                    state_d = S_EXEC;
                end else if (HALT_ON_ILLEGAL) begin
                    state_d = S_HALT;
                end else begin
                    retire = 1'b1;
                end
            end
            S_EXEC: begin
                if (is_branch) begin
                    retire = 1'b1;
                end else if (is_load || is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (is_store) begin
                    retire = 1'b1;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                retire = 1'b1;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Completion cycle: count it and pick the next boundary.
        if (retire) begin
            cnt_d   = cnt_q + COUNT_W'(1);
            state_d = run ? S_FETCH : S_IDLE;
        end

        // Output values for the cycle the FSM is about to enter.
        we_mem_d   = 1'b0;
        we_reg_d   = 1'b0;
        op_mem_i_d = 2'b00;
        add_sub_d  = 1'b0;
        pc_load_d  = 1'b0;
        sel_d      = SEL_PC_INC;
        halted_d   = 1'b0;

        case (state_d)
            S_DECODE: begin
                // Illegal opcode retired as a NOP advances the PC here.
                if (!is_legal && !HALT_ON_ILLEGAL) pc_load_d = 1'b1;
            end
            S_EXEC: begin
                add_sub_d     = alu_sub;
                op_mem_i_d[0] = alu_imm;
                if (is_branch) begin
                    pc_load_d = 1'b1;
                    sel_d     = branch_sel;
                end
            end
            S_MEM: begin
                add_sub_d     = alu_sub;
                op_mem_i_d[0] = alu_imm;
                if (is_store) begin
                    we_mem_d  = 1'b1;
                    pc_load_d = 1'b1;
                end
            end
            S_WB: begin
                add_sub_d     = alu_sub;
                op_mem_i_d[0] = alu_imm;
                op_mem_i_d[1] = is_load;
                we_reg_d      = 1'b1;
                pc_load_d     = 1'b1;
            end
            S_HALT: begin
                halted_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM register with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            ir_q       <= '0;
            cnt_q      <= '0;
            we_mem_q   <= 1'b0;
            we_reg_q   <= 1'b0;
            op_mem_i_q <= 2'b00;
            add_sub_q  <= 1'b0;
            pc_load_q  <= 1'b0;
            sel_q      <= SEL_PC_INC;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            cnt_q      <= cnt_d;
            we_mem_q   <= we_mem_d;
            we_reg_q   <= we_reg_d;
            op_mem_i_q <= op_mem_i_d;
            add_sub_q  <= add_sub_d;
            pc_load_q  <= pc_load_d;
            sel_q      <= sel_d;
            halted_q   <= halted_d;
        end
    end

    assign WE_mem       = we_mem_q;
    assign WE_reg       = we_reg_q;
    assign OP_MEM_I     = op_mem_i_q;
    assign ADD_SUB      = add_sub_q;
    assign PC_load      = pc_load_q;
    assign select_flags = sel_q;
    assign state        = state_q;
    assign instr_count  = cnt_q;
    assign halted       = halted_q;

endmodule

// File: tb/tb_control_unit_mc.sv
// Bench for control_unit_mc. Three instances share the stimulus: the default
// configuration, one that retires illegal opcodes as NOPs, and one with a
// 4-bit retired counter. Expected per-cycle output vectors are pushed to a
// queue when an instruction is issued and popped one per cycle.
module tb_control_unit_mc;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LD  = 7'b0000011;
  localparam logic [6:0] OPC_ST  = 7'b0100011;
  localparam logic [6:0] OPC_BR  = 7'b1100011;
  localparam logic [6:0] OPC_ILL = 7'b1101111;

  logic        clk;
  logic        reset;
  logic        run;
  logic [31:0] instruction;

  logic        we_mem, we_reg, add_sub, pc_load, halted;
  logic [1:0]  op_mem_i;
  logic [2:0]  select_flags, state;
  logic [15:0] instr_count;

  logic        n_we_mem, n_we_reg, n_add_sub, n_pc_load, n_halted;
  logic [1:0]  n_op_mem_i;
  logic [2:0]  n_select_flags, n_state;
  logic [15:0] n_instr_count;

  logic        w_we_mem, w_we_reg, w_add_sub, w_pc_load, w_halted;
  logic [1:0]  w_op_mem_i;
  logic [2:0]  w_select_flags, w_state;
  logic [3:0]  w_instr_count;

  int n_checks;
  int n_fail;
  int exp_cnt;
  logic [12:0] exp_q[$];

  control_unit_mc #(.COUNT_W(16), .HALT_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .reset(reset), .run(run), .instruction(instruction),
    .WE_mem(we_mem), .WE_reg(we_reg), .OP_MEM_I(op_mem_i), .ADD_SUB(add_sub),
    .PC_load(pc_load), .select_flags(select_flags), .state(state),
    .instr_count(instr_count), .halted(halted)
  );

  control_unit_mc #(.COUNT_W(16), .HALT_ON_ILLEGAL(1'b0)) dut_nop (
    .clk(clk), .reset(reset), .run(run), .instruction(instruction),
    .WE_mem(n_we_mem), .WE_reg(n_we_reg), .OP_MEM_I(n_op_mem_i), .ADD_SUB(n_add_sub),
    .PC_load(n_pc_load), .select_flags(n_select_flags), .state(n_state),
    .instr_count(n_instr_count), .halted(n_halted)
  );

  control_unit_mc #(.COUNT_W(4), .HALT_ON_ILLEGAL(1'b1)) dut_w4 (
    .clk(clk), .reset(reset), .run(run), .instruction(instruction),
    .WE_mem(w_we_mem), .WE_reg(w_we_reg), .OP_MEM_I(w_op_mem_i), .ADD_SUB(w_add_sub),
    .PC_load(w_pc_load), .select_flags(w_select_flags), .state(w_state),
    .instr_count(w_instr_count), .halted(w_halted)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [12:0] pack(input logic [2:0] st, input logic wm, input logic wr,
                                       input logic [1:0] op, input logic as, input logic pl,
                                       input logic [2:0] sel, input logic h);
    return {st, wm, wr, op, as, pl, sel, h};
  endfunction

  function automatic logic [12:0] obs_vec();
    return pack(state, we_mem, we_reg, op_mem_i, add_sub, pc_load, select_flags, halted);
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] opc);
    logic [4:0] rs2, rs1, rd;
    rs2 = 5'($urandom);
    rs1 = 5'($urandom);
    rd  = 5'($urandom);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  // Reference model: expected output vector for every cycle of one
  // instruction, FETCH through its completion cycle.
  task automatic push_trace(input logic [31:0] instr, output bit legal);
    logic [6:0] opc;
    logic [2:0] f3, sel;
    bit r, i, ld, st, br;
    logic as, op0;
    opc = instr[6:0];
    f3  = instr[14:12];
    r = (opc == OPC_R); i = (opc == OPC_I); ld = (opc == OPC_LD);
    st = (opc == OPC_ST); br = (opc == OPC_BR);
    legal = r || i || ld || st || br;
    as  = (r && f3 == 3'b000 && instr[30]) || br;
    op0 = i || ld || st;
    case (f3)
      3'b000: sel = 3'd0;
      3'b001: sel = 3'd1;
      3'b100: sel = 3'd2;
      3'b101: sel = 3'd3;
      3'b110: sel = 3'd4;
      3'b111: sel = 3'd5;
      default: sel = 3'd6;
    endcase
    exp_q.push_back(pack(3'd1, 0, 0, 2'b00, 0, 0, 3'd6, 0));
    exp_q.push_back(pack(3'd2, 0, 0, 2'b00, 0, 0, 3'd6, 0));
    if (legal) begin
      if (br) begin
        exp_q.push_back(pack(3'd3, 0, 0, {1'b0, op0}, as, 1, sel, 0));
      end else begin
        exp_q.push_back(pack(3'd3, 0, 0, {1'b0, op0}, as, 0, 3'd6, 0));
        if (ld || st)
          exp_q.push_back(pack(3'd4, st, 0, {1'b0, op0}, as, st, 3'd6, 0));
        if (!st)
          exp_q.push_back(pack(3'd5, 0, 1, {ld, op0}, as, 1, 3'd6, 0));
      end
    end
  endtask

  // Called at a negedge where the DUT will enter FETCH at the next posedge.
  task automatic run_instr(input logic [31:0] instr, input int drop_at);
    bit legal;
    int n;
    logic [12:0] e;
    push_trace(instr, legal);
    n = exp_q.size();
    instruction = instr;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      e = exp_q.pop_front();
      check("trace", 32'(obs_vec()), 32'(e));
      check("cnt", 32'(instr_count), 32'(exp_cnt & 16'hFFFF));
      check("cnt_w4", 32'(w_instr_count), 32'(exp_cnt & 4'hF));
      if (!legal && k == 1) begin
        check("nop_state", 32'(n_state), 32'd2);
        check("nop_pc_load", 32'(n_pc_load), 32'd1);
        check("nop_sel", 32'(n_select_flags), 32'd6);
        check("nop_we", 32'({n_we_mem, n_we_reg}), 32'd0);
      end
      if (k == drop_at) run = 1'b0;
    end
    if (legal) exp_cnt++;
  endtask

  initial begin
    logic [31:0] ins;
    int kind;
    n_checks = 0;
    n_fail   = 0;
    exp_cnt  = 0;
    reset = 1'b0;
    run = 1'b0;
    instruction = 32'd0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_vec", 32'(obs_vec()), 32'(pack(3'd0, 0, 0, 2'b00, 0, 0, 3'd6, 0)));
    check("rst_cnt", 32'(instr_count), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_hold", 32'(state), 32'd0);
    run = 1'b1;

    // directed sequence
    run_instr(mk(7'b0100000, 3'b000, OPC_R), -1);       // sub
    run_instr(mk(7'b0000000, 3'b000, OPC_R), -1);       // add
    run_instr(mk(7'($urandom), 3'b010, OPC_I), -1);
    run_instr(mk(7'($urandom), 3'b010, OPC_LD), -1);
    run_instr(mk(7'($urandom), 3'b010, OPC_ST), -1);
    run_instr(mk(7'($urandom), 3'b101, OPC_BR), -1);
    run_instr(mk(7'($urandom), 3'b011, OPC_BR), -1);

    // random legal instructions
    for (int i = 0; i < 10; i++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0: ins = mk(7'($urandom), 3'($urandom), OPC_R);
        1: ins = mk(7'($urandom), 3'($urandom), OPC_I);
        2: ins = mk(7'($urandom), 3'($urandom), OPC_LD);
        3: ins = mk(7'($urandom), 3'($urandom), OPC_ST);
        default: ins = mk(7'($urandom), 3'($urandom), OPC_BR);
      endcase
      run_instr(ins, -1);
    end

    // run dropped in EXEC: instruction finishes, then IDLE
    run_instr(mk(7'b0100000, 3'b000, OPC_R), 2);
    @(negedge clk);
    check("drop_idle", 32'(state), 32'd0);
    check("drop_cnt", 32'(instr_count), 32'(exp_cnt));
    @(negedge clk);
    check("drop_idle2", 32'(state), 32'd0);

    // async reset during MEM of a STORE
    run = 1'b1;
    instruction = mk(7'($urandom), 3'b010, OPC_ST);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("st_mem_state", 32'(state), 32'd4);
    check("st_mem_we", 32'(we_mem), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("rst_we_mem", 32'(we_mem), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_cnt_mid", 32'(instr_count), 32'd0);
    check("rst_cnt_w4", 32'(w_instr_count), 32'd0);
    exp_cnt = 0;
    run = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_idle", 32'(state), 32'd0);
    run = 1'b1;

    // 16 back-to-back I-ALU: 4-bit counter wraps 15 -> 0
    for (int i = 0; i < 16; i++) run_instr(mk(7'($urandom), 3'($urandom), OPC_I), -1);

    // illegal opcode: default instance halts, NOP instance retires it
    run_instr(mk(7'($urandom), 3'($urandom), OPC_ILL), -1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("halt_vec", 32'(obs_vec()), 32'(pack(3'd7, 0, 0, 2'b00, 0, 0, 3'd6, 1)));
      check("halt_cnt", 32'(instr_count), 32'(exp_cnt));
      if (i == 0) begin
        check("nop_next_state", 32'(n_state), 32'd1);
        check("nop_cnt", 32'(n_instr_count), 32'(exp_cnt + 1));
        check("w4_halt_cnt", 32'(w_instr_count), 32'd0);
        check("w4_halted", 32'(w_halted), 32'd1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
